// File: rtl/rdout_seq_if.sv
// Bus bundle between the readout sequencer and its environment
// (trigger/L1A FIFOs, ADC/SCA digitizer, output data FIFO, block pool).
interface rdout_seq_if;
  logic       ENBL;
  logic       TEMPTY;
  logic       L1MT;
  logic [3:0] BLKOUT;
  logic       SCND_BLK;
  logic [5:0] L1ANUM;
  logic       DFIFO_AFULL;
  logic       ADC_DONE;

  logic       CONV_REQ;
  logic [3:0] RD_BLK;
  logic [3:0] RD_SMPL;
  logic       HDR_WR;
  logic       TRL_WR;
  logic [5:0] HDR_DATA;
  logic       TRGDONE;
  logic       POPL1AN;
  logic       FREE_BLK;
  logic [3:0] FREE_NUM;
  logic       BUSY;
  logic       ERR;

  // Sequencer side.
  modport master (
    input  ENBL, TEMPTY, L1MT, BLKOUT, SCND_BLK, L1ANUM, DFIFO_AFULL, ADC_DONE,
    output CONV_REQ, RD_BLK, RD_SMPL, HDR_WR, TRL_WR, HDR_DATA,
           TRGDONE, POPL1AN, FREE_BLK, FREE_NUM, BUSY, ERR
  );

  // Environment side.
  modport slave (
    output ENBL, TEMPTY, L1MT, BLKOUT, SCND_BLK, L1ANUM, DFIFO_AFULL, ADC_DONE,
    input  CONV_REQ, RD_BLK, RD_SMPL, HDR_WR, TRL_WR, HDR_DATA,
           TRGDONE, POPL1AN, FREE_BLK, FREE_NUM, BUSY, ERR
  );
endinterface

// File: rtl/rdout_seq.sv
// Readout sequencer: per event emits header, SCA conversions (one or two blocks), trailer,
// then pops both FIFOs and frees the blocks. Define RDSEQ_ADC_TMO_EN for the ADC timeout watchdog.
module rdout_seq #(
  parameter int NSAMP = 8,
  parameter int NBLK  = 12
) (
  input  logic        CLK,
  input  logic        RST,
  rdout_seq_if.master bus
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LATCH = 4'd1;
  localparam logic [3:0] HDR   = 4'd2;
  localparam logic [3:0] CONV  = 4'd3;
  localparam logic [3:0] WAIT  = 4'd4;
  localparam logic [3:0] NEXT  = 4'd5;
  localparam logic [3:0] TRL   = 4'd6;
  localparam logic [3:0] DONE  = 4'd7;
  localparam logic [3:0] FREE2 = 4'd8;

  localparam logic [3:0] LAST_SMPL = 4'(NSAMP - 1);
  localparam logic [3:0] LAST_BLK  = 4'(NBLK - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] blk_a_q, blk_a_d;
  logic [3:0] blk_b_q, blk_b_d;
  logic       two_blk_q, two_blk_d;
  logic       cur_q, cur_d;
  logic [3:0] smpl_q, smpl_d;
  logic [5:0] hdr_data_q, hdr_data_d;
  logic [3:0] rd_blk_q, rd_blk_d;
  logic [3:0] rd_smpl_q, rd_smpl_d;
  logic [3:0] free_num_q, free_num_d;
  logic       conv_req_q, conv_req_d;
  logic       hdr_wr_q, hdr_wr_d;
  logic       trl_wr_q, trl_wr_d;
  logic       trgdone_q, trgdone_d;
  logic       free_blk_q, free_blk_d;
`ifdef RDSEQ_ADC_TMO_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    blk_a_d    = blk_a_q;
    blk_b_d    = blk_b_q;
    two_blk_d  = two_blk_q;
    cur_d      = cur_q;
    smpl_d     = smpl_q;
    hdr_data_d = hdr_data_q;
    rd_blk_d   = rd_blk_q;
    rd_smpl_d  = rd_smpl_q;
    free_num_d = free_num_q;
    conv_req_d = 1'b0;
    hdr_wr_d   = 1'b0;
    trl_wr_d   = 1'b0;
    trgdone_d  = 1'b0;
    free_blk_d = 1'b0;
`ifdef RDSEQ_ADC_TMO_EN
    tmo_d      = 8'd0;
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: if (bus.ENBL && !bus.TEMPTY && !bus.L1MT) state_d = LATCH;
      LATCH: begin
        blk_a_d    = bus.BLKOUT;
        blk_b_d    = (bus.BLKOUT == LAST_BLK) ? 4'd0 : bus.BLKOUT + 4'd1;
        two_blk_d  = bus.SCND_BLK;
        hdr_data_d = bus.L1ANUM;
        smpl_d     = 4'd0;
        cur_d      = 1'b0;
        state_d    = HDR;
      end
      HDR: if (!bus.DFIFO_AFULL) begin
        hdr_wr_d = 1'b1;
        state_d  = CONV;
      end
      CONV: if (!bus.DFIFO_AFULL) begin
        conv_req_d = 1'b1;
        rd_blk_d   = cur_q ? blk_b_q : blk_a_q;
        rd_smpl_d  = smpl_q;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.ADC_DONE) state_d = NEXT;
`ifdef RDSEQ_ADC_TMO_EN
        // 255th WAIT cycle without ADC_DONE: flag it and carry on as if it arrived.
        else if (tmo_q == 8'd254) begin
          err_d   = 1'b1;
          state_d = NEXT;
        end else tmo_d = tmo_q + 8'd1;
`endif
      end
      NEXT: begin
        if (smpl_q < LAST_SMPL) begin
          smpl_d  = smpl_q + 4'd1;
          state_d = CONV;
        end else if (two_blk_q && !cur_q) begin
          cur_d   = 1'b1;
          smpl_d  = 4'd0;
          state_d = CONV;
        end else state_d = TRL;
      end
      TRL: if (!bus.DFIFO_AFULL) begin
        trl_wr_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        trgdone_d  = 1'b1;
        free_blk_d = 1'b1;
        free_num_d = blk_a_q;
        state_d    = two_blk_q ? FREE2 : IDLE;
      end
      FREE2: begin
        free_blk_d = 1'b1;
        free_num_d = blk_b_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      blk_a_q    <= 4'd0;
      blk_b_q    <= 4'd0;
      two_blk_q  <= 1'b0;
      cur_q      <= 1'b0;
      smpl_q     <= 4'd0;
      hdr_data_q <= 6'd0;
      rd_blk_q   <= 4'd0;
      rd_smpl_q  <= 4'd0;
      free_num_q <= 4'd0;
      conv_req_q <= 1'b0;
      hdr_wr_q   <= 1'b0;
      trl_wr_q   <= 1'b0;
      trgdone_q  <= 1'b0;
      free_blk_q <= 1'b0;
`ifdef RDSEQ_ADC_TMO_EN
      tmo_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      blk_a_q    <= blk_a_d;
      blk_b_q    <= blk_b_d;
      two_blk_q  <= two_blk_d;
      cur_q      <= cur_d;
      smpl_q     <= smpl_d;
      hdr_data_q <= hdr_data_d;
      rd_blk_q   <= rd_blk_d;
      rd_smpl_q  <= rd_smpl_d;
      free_num_q <= free_num_d;
      conv_req_q <= conv_req_d;
      hdr_wr_q   <= hdr_wr_d;
      trl_wr_q   <= trl_wr_d;
      trgdone_q  <= trgdone_d;
      free_blk_q <= free_blk_d;
`ifdef RDSEQ_ADC_TMO_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.CONV_REQ = conv_req_q;
  assign bus.RD_BLK   = rd_blk_q;
  assign bus.RD_SMPL  = rd_smpl_q;
  assign bus.HDR_WR   = hdr_wr_q;
  assign bus.TRL_WR   = trl_wr_q;
  assign bus.HDR_DATA = hdr_data_q;
  assign bus.TRGDONE  = trgdone_q;
  assign bus.POPL1AN  = trgdone_q;
  assign bus.FREE_BLK = free_blk_q;
  assign bus.FREE_NUM = free_num_q;
  assign bus.BUSY     = (state_q != IDLE);
`ifdef RDSEQ_ADC_TMO_EN
  assign bus.ERR      = err_q;
`else
  assign bus.ERR      = 1'b0;
`endif

endmodule
